// File: rtl/eic_pkg.sv
// Shared definitions for the ext_int_ctrl_n external interrupt controller:
// register map, STATUS bit positions, handshake FSM states and the urgent ID.
package eic_pkg;

  localparam logic [3:0] EIC_REG_ENABLE   = 4'd0;
  localparam logic [3:0] EIC_REG_PENDING  = 4'd1;
  localparam logic [3:0] EIC_REG_MODE     = 4'd2;
  localparam logic [3:0] EIC_REG_POLARITY = 4'd3;
  localparam logic [3:0] EIC_REG_STATUS   = 4'd4;

  localparam int unsigned STATUS_BUSY_BIT   = 31;
  localparam int unsigned STATUS_URGENT_BIT = 30;

  localparam int unsigned URGENT_ID = 0;

  typedef enum logic [1:0] {
    EIC_IDLE = 2'd0,
    EIC_REQ  = 2'd1,
    EIC_HOLD = 2'd2
  } eic_state_t;

endpackage

// File: rtl/eic_prio_enc.sv
// Fixed-priority encoder: urgent wins, then the lowest-index candidate channel.
// ID 0 is urgent; channel i maps to ID i+1.
module eic_prio_enc
  import eic_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned ID_W   = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0] cand,
  input  logic              urgent,
  output logic              valid_c,
  output logic [ID_W-1:0]   id_c
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    valid_c = urgent | (|cand);
    id_c    = ID_W'(URGENT_ID);
    if (!urgent) begin
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (cand[i]) id_c = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/ext_int_ctrl_n.sv
// Parametrised external interrupt controller (1..31 channels plus an urgent input).
// Optional build macro EIC_SYNC_EN adds 2-flop input synchronisers on IntReq/UrgentReq.
module ext_int_ctrl_n
  import eic_pkg::*;
#(
  parameter  int unsigned NUM_CH = 8,
  localparam int unsigned ID_W   = $clog2(NUM_CH + 1)
) (
  input  logic              Sys_Clock,
  input  logic              Sys_Reset,
  input  logic              Sys_BlockSelect,
  input  logic [3:0]        Sys_RegAddress,
  input  logic              Sys_WrEn,
  input  logic              Sys_RdEn,
  input  logic [31:0]       Sys_WrData,
  output logic [31:0]       Sys_RdData,
  input  logic [NUM_CH-1:0] IntReq,
  input  logic              UrgentReq,
  output logic              K_IntReq,
  output logic [ID_W-1:0]   K_IntID,
  input  logic              I_IntAck
);

  logic [NUM_CH-1:0] chIn;
  logic              urgIn;

`ifdef EIC_SYNC_EN
  logic [NUM_CH-1:0] chSync1, chSync2;
  logic              urgSync1, urgSync2;

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      chSync1  <= '0;
      chSync2  <= '0;
      urgSync1 <= 1'b0;
      urgSync2 <= 1'b0;
    end else begin
      chSync1  <= IntReq;
      chSync2  <= chSync1;
      urgSync1 <= UrgentReq;
      urgSync2 <= urgSync1;
    end
  end

  assign chIn  = chSync2;
  assign urgIn = urgSync2;
`else
  assign chIn  = IntReq;
  assign urgIn = UrgentReq;
`endif

  logic [NUM_CH-1:0] enableReg, pendReg, modeReg, polReg, chHist;
  logic              urgentPend, urgHist;
  eic_state_t        state, nextState;

  logic [NUM_CH-1:0] chActive, chEdge, w1cMask, ackMask, pendNext, candVec;
  logic              regWr, regRd, ackFire, loadId, urgentNext, candValid;
  logic [ID_W-1:0]   candId;
  logic [31:0]       rdMux, statusWord;
  logic              unusedWrBits;

  assign unusedWrBits = ^Sys_WrData[31:NUM_CH];

  assign regWr    = Sys_BlockSelect & Sys_WrEn;
  assign regRd    = Sys_BlockSelect & Sys_RdEn;
  assign chActive = chIn ^ polReg;
  assign chEdge   = chActive & ~chHist;
  assign w1cMask  = (regWr && (Sys_RegAddress == EIC_REG_PENDING)) ? Sys_WrData[NUM_CH-1:0] : '0;
  assign candVec  = pendReg & enableReg;

  // Ack clears only the latched channel; level channels ignore it through the mode mux.
  always_comb begin
    ackMask = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ackMask[i] = ackFire && (K_IntID == ID_W'(i + 1));
    end
  end

  // Set events are ORed in last so they win over W1C and ack clears.
  assign pendNext   = (modeReg & ((pendReg & ~w1cMask & ~ackMask) | chEdge))
                    | (~modeReg & chActive);
  assign urgentNext = (urgentPend & ~(ackFire && (K_IntID == ID_W'(URGENT_ID))))
                    | (urgIn & ~urgHist);

  eic_prio_enc #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_prio (
    .cand    (candVec),
    .urgent  (urgentPend),
    .valid_c (candValid),
    .id_c    (candId)
  );

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) state <= EIC_IDLE;
    else            state <= nextState;
  end

  always_comb begin
    nextState = state;
    loadId    = 1'b0;
    ackFire   = 1'b0;
    case (state)
      EIC_IDLE: begin
        if (candValid) begin
          nextState = EIC_REQ;
          loadId    = 1'b1;
        end
      end
      EIC_REQ: begin
        if (I_IntAck) begin
          nextState = EIC_HOLD;
          ackFire   = 1'b1;
        end
      end
      EIC_HOLD: begin
        if (!I_IntAck) nextState = EIC_IDLE;
      end
      default: nextState = EIC_IDLE;
    endcase
  end

  always_comb begin
    statusWord                    = '0;
    statusWord[STATUS_BUSY_BIT]   = (state != EIC_IDLE);
    statusWord[STATUS_URGENT_BIT] = urgentPend;
    statusWord[ID_W-1:0]          = K_IntID;
  end

  always_comb begin
    rdMux = '0;
    case (Sys_RegAddress)
      EIC_REG_ENABLE:   rdMux = 32'(enableReg);
      EIC_REG_PENDING:  rdMux = 32'(pendReg);
      EIC_REG_MODE:     rdMux = 32'(modeReg);
      EIC_REG_POLARITY: rdMux = 32'(polReg);
      EIC_REG_STATUS:   rdMux = statusWord;
      default:          rdMux = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      K_IntReq   <= 1'b0;
      K_IntID    <= '0;
      Sys_RdData <= '0;
    end else begin
      K_IntReq   <= (nextState == EIC_REQ);
      if (loadId) K_IntID <= candId;
      Sys_RdData <= regRd ? rdMux : '0;
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      enableReg  <= '0;
      pendReg    <= '0;
      modeReg    <= '0;
      polReg     <= '0;
      chHist     <= '0;
      urgentPend <= 1'b0;
      urgHist    <= 1'b0;
    end else begin
      pendReg    <= pendNext;
      chHist     <= chActive;
      urgentPend <= urgentNext;
      urgHist    <= urgIn;
      if (regWr) begin
        case (Sys_RegAddress)
          EIC_REG_ENABLE:   enableReg <= Sys_WrData[NUM_CH-1:0];
          EIC_REG_MODE:     modeReg   <= Sys_WrData[NUM_CH-1:0];
          EIC_REG_POLARITY: polReg    <= Sys_WrData[NUM_CH-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl_n.sv
// Self-checking bench for ext_int_ctrl_n: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_ext_int_ctrl_n;

  localparam int unsigned NCH = 8;
  localparam int unsigned IDW = $clog2(NCH + 1);
`ifdef EIC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam logic [31:0] CH_MASK = 32'h0000_00FF;

  logic           clk = 1'b0;
  logic           rstN = 1'b1;
  logic           sel = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [3:0]     addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdData;
  logic [NCH-1:0] intReq = '0;
  logic           urg = 1'b0;
  logic           kReq;
  logic [IDW-1:0] kId;
  logic           ack = 1'b0;

  int checks = 0;
  int errors = 0;

  ext_int_ctrl_n #(.NUM_CH(NCH)) dut (
    .Sys_Clock       (clk),
    .Sys_Reset       (rstN),
    .Sys_BlockSelect (sel),
    .Sys_RegAddress  (addr),
    .Sys_WrEn        (wr),
    .Sys_RdEn        (rd),
    .Sys_WrData      (wdata),
    .Sys_RdData      (rdData),
    .IntReq          (intReq),
    .UrgentReq       (urg),
    .K_IntReq        (kReq),
    .K_IntID         (kId),
    .I_IntAck        (ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain words, handshake as a phase number
  // (0 idle, 1 requesting, 2 waiting for ack release).
  bit [31:0] mEn, mPend, mMode, mPol, mHist, mS1, mS2, mRd;
  bit        mUrg, mUrgHist, mUS1, mUS2, mReq;
  int        mPhase, mId;
  bit [31:0] inNow, act, newPend;
  bit        uNow, ackNow, p, newUrg;
  int        best;

  function automatic int pickId();
    if (mUrg) return 0;
    for (int c = 0; c < int'(NCH); c++) if (mPend[c] && mEn[c]) return c + 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mEn = 0; mPend = 0; mMode = 0; mPol = 0; mHist = 0; mS1 = 0; mS2 = 0; mRd = 0;
      mUrg = 0; mUrgHist = 0; mUS1 = 0; mUS2 = 0; mReq = 0; mPhase = 0; mId = 0;
    end else begin
      inNow = (SYNC_LAT != 0) ? mS2 : 32'(intReq);
      uNow  = (SYNC_LAT != 0) ? mUS2 : urg;
      mS2 = mS1; mS1 = 32'(intReq); mUS2 = mUS1; mUS1 = urg;
      act = (inNow ^ mPol) & CH_MASK;

      mRd = 0;
      if (sel && rd) begin
        case (addr)
          4'd0: mRd = mEn;
          4'd1: mRd = mPend;
          4'd2: mRd = mMode;
          4'd3: mRd = mPol;
          4'd4: mRd = {(mPhase != 0), mUrg, 30'(mId)};
          default: mRd = 0;
        endcase
      end

      ackNow = (mPhase == 1) && ack;
      newPend = 0;
      for (int c = 0; c < int'(NCH); c++) begin
        if (mMode[c]) begin
          p = mPend[c];
          if (sel && wr && addr == 4'd1 && wdata[c]) p = 0;
          if (ackNow && mId == c + 1) p = 0;
          if (act[c] && !mHist[c]) p = 1;
          newPend[c] = p;
        end else begin
          newPend[c] = act[c];
        end
      end
      newUrg = mUrg;
      if (ackNow && mId == 0) newUrg = 0;
      if (uNow && !mUrgHist) newUrg = 1;

      case (mPhase)
        0: begin
          best = pickId();
          if (best >= 0) begin mId = best; mPhase = 1; end
        end
        1: if (ack) mPhase = 2;
        default: if (!ack) mPhase = 0;
      endcase
      mReq = (mPhase == 1);

      if (sel && wr) begin
        if (addr == 4'd0) mEn   = wdata & CH_MASK;
        if (addr == 4'd2) mMode = wdata & CH_MASK;
        if (addr == 4'd3) mPol  = wdata & CH_MASK;
      end
      mHist = act; mUrgHist = uNow; mPend = newPend; mUrg = newUrg;
    end
  end

  always @(negedge clk) begin
    chk("modelReq", 32'(kReq), 32'(mReq));
    chk("modelId", 32'(kId), 32'(mId));
    chk("modelRdData", rdData, mRd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrReg(input logic [3:0] a, input logic [31:0] d);
    sel = 1; wr = 1; addr = a; wdata = d;
    tick();
    sel = 0; wr = 0; wdata = '0;
  endtask

  task automatic rdReg(input logic [3:0] a, input logic [31:0] exp, input string nm);
    sel = 1; rd = 1; addr = a;
    tick();
    sel = 0; rd = 0;
    chk(nm, rdData, exp);
  endtask

  task automatic waitReq(input int maxCyc);
    int n = 0;
    while (kReq !== 1'b1 && n < maxCyc) begin
      tick();
      n++;
    end
    chk("waitReq", 32'(kReq), 32'd1);
  endtask

  task automatic doAck();
    ack = 1;
    tick();
    chk("ackDrop", 32'(kReq), 32'd0);
    ack = 0;
  endtask

  initial begin
    #1 rstN = 0;
    repeat (3) tick();
    rstN = 1;
    tick();
    chk("resetReq", 32'(kReq), 32'd0);
    for (int a = 0; a < 16; a++) rdReg(4'(a), 32'd0, "resetRead");

    // Two edges at once: lowest channel first
    wrReg(4'd0, 32'hFF);
    wrReg(4'd2, 32'hFF);
    intReq = 8'h24; tick(); intReq = '0;
    waitReq(20);
    chk("firstId", 32'(kId), 32'd3);
    doAck();
    waitReq(10);
    chk("secondId", 32'(kId), 32'd6);
    doAck();
    tick(); tick();
    rdReg(4'd1, 32'd0, "pendEmpty");

    // Urgent arrives during channel 0 request
    intReq = 8'h01; tick(); intReq = '0;
    waitReq(20);
    chk("ch0Id", 32'(kId), 32'd1);
    urg = 1; tick(); tick(); urg = 0;
    repeat (SYNC_LAT + 2) tick();
    chk("noPreempt", 32'(kId), 32'd1);
    rdReg(4'd4, 32'hC000_0001, "statusBusyUrg");
    doAck();
    waitReq(10);
    chk("urgId", 32'(kId), 32'd0);
    doAck();
    tick();
    rdReg(4'd4, 32'd0, "statusClear");

    // Level mode, active-low channel 1
    wrReg(4'd0, 32'h00);
    wrReg(4'd2, 32'h00);
    wrReg(4'd3, 32'h02);
    wrReg(4'd0, 32'h02);
    waitReq(10);
    chk("lvlId1", 32'(kId), 32'd2);
    wrReg(4'd1, 32'h02);
    rdReg(4'd1, 32'h02, "lvlW1c");
    doAck();
    waitReq(10);
    chk("lvlId2", 32'(kId), 32'd2);
    intReq[1] = 1;
    repeat (SYNC_LAT) tick();
    doAck();
    repeat (SYNC_LAT + 6) tick();
    chk("lvlQuiet", 32'(kReq), 32'd0);
    wrReg(4'd0, 32'h00);
    wrReg(4'd3, 32'h00);
    intReq = '0;
    repeat (SYNC_LAT + 3) tick();

    // Masked edge channel 4, then enable
    wrReg(4'd2, 32'h10);
    intReq[4] = 1; tick(); intReq[4] = 0;
    repeat (SYNC_LAT + 2) tick();
    rdReg(4'd1, 32'h10, "maskedPend");
    chk("maskedNoReq", 32'(kReq), 32'd0);
    wrReg(4'd0, 32'h10);
    tick();
    chk("enReq", 32'(kReq), 32'd1);
    chk("enId", 32'(kId), 32'd5);
    doAck();
    tick();
    rdReg(4'd1, 32'd0, "ackClearedPend");

    // W1C colliding with a new edge: set wins
    intReq[4] = 1;
    repeat (SYNC_LAT) tick();
    sel = 1; wr = 1; addr = 4'd1; wdata = 32'h10;
    tick();
    sel = 0; wr = 0; wdata = '0; intReq[4] = 0;
    rdReg(4'd1, 32'h10, "setWins");
    waitReq(10);
    chk("setWinsId", 32'(kId), 32'd5);

    // Asynchronous reset mid-handshake
    chk("preRstReq", 32'(kReq), 32'd1);
    @(posedge clk);
    #3 rstN = 0;
    #1 chk("asyncDrop", 32'(kReq), 32'd0);
    tick(); tick();
    rstN = 1;
    repeat (10) tick();
    chk("postRstQuiet", 32'(kReq), 32'd0);
    rdReg(4'd1, 32'd0, "postRstPend");
    rdReg(4'd0, 32'd0, "postRstEn");

    // Recovery with a fresh edge
    wrReg(4'd0, 32'h01);
    wrReg(4'd2, 32'h01);
    intReq[0] = 1; tick(); intReq[0] = 0;
    waitReq(10);
    chk("recoverId", 32'(kId), 32'd1);
    doAck();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl_n.md
# ext_int_ctrl_n

Parametrised external interrupt controller for the Kabeta I/O subsystem. It is the successor to the fixed 8-input controller and supports 1..31 channels. Each channel has an edge or level mode, a polarity, enable masking and write-1-to-clear pending bits, plus one unmaskable urgent input. Fixed-priority arbitration presents one request at a time to the processor through the K_IntReq/K_IntID/I_IntAck handshake. It occupies one block slot of the I/O address decoder and is programmed through the 4-bit register address of that slot.

## Interface
Parameters:
- NUM_CH, default 8: number of normal interrupt channels; legal range 1..31.
- ID_W, default $clog2(NUM_CH+1): width of K_IntID. Localparam derived from NUM_CH; not overridable.

Ports:
- Sys_Clock  in  1  single clock for all logic.
- Sys_Reset  in  1  asynchronous, active-low reset.
- Sys_BlockSelect  in  1  this block is addressed by the I/O decoder.
- Sys_RegAddress  in  4  register index.
- Sys_WrEn  in  1  write strobe, qualified by Sys_BlockSelect.
- Sys_RdEn  in  1  read strobe, qualified by Sys_BlockSelect.
- Sys_WrData  in  32  write data.
- Sys_RdData  out  32  registered read data.
- IntReq  in  NUM_CH  external channel inputs, raw.
- UrgentReq  in  1  unmaskable urgent input, rising-edge sensitive.
- K_IntReq  out  1  interrupt request to the processor.
- K_IntID  out  ID_W  requested ID: 0 = urgent; i+1 = channel i.
- I_IntAck  in  1  acknowledge from the processor.

## Operation
Registers (bits above NUM_CH-1 read 0 and ignore writes):
- 0 ENABLE, RW, reset 0: per-channel mask.
- 1 PENDING, R/W1C, reset 0: in level mode the bit mirrors the active input level and W1C has no effect.
- 2 MODE, RW, reset 0: 1 = edge, 0 = level.
- 3 POLARITY, RW, reset 0: 0 = active-high / rising edge; 1 = active-low / falling edge.
- 4 STATUS, R: bit31 = busy (FSM not IDLE); bit30 = urgent pending; [ID_W-1:0] = latched ID.
- 5..15: read 0; writes ignored.

Input handling:
- Each channel input is XORed with its POLARITY bit.
- Edge channels latch pending on a detected active edge, regardless of ENABLE.
- A set event and a W1C of the same bit in the same cycle: set wins.
- A rising edge on UrgentReq sets urgent_pend. urgent_pend clears only on the acknowledge of ID 0.

Arbitration:
- Candidate set = urgent_pend, then (PENDING & ENABLE).
- Priority order: urgent first, then the lowest channel index.

FSM, states IDLE, REQ, HOLD:
- IDLE: if any candidate exists, latch its ID into K_IntID and go to REQ.
- REQ: K_IntReq = 1 and K_IntID is stable. On I_IntAck = 1: clear urgent_pend (ID 0) or the edge-mode pending bit of the channel; then go to HOLD.
- HOLD: K_IntReq = 0. Wait for I_IntAck = 0, then go to IDLE.
- No preemption. A higher-priority arrival during REQ waits its turn.
- Disabling or clearing the latched channel while in REQ does not withdraw the request. The processor still acknowledges it, and the ack clear is harmless.
- A level channel still active after HOLD re-requests from IDLE.

## Timing
- Reset values: Sys_RdData = 0, K_IntReq = 0, K_IntID = 0, FSM = IDLE, and all registers and edge history = 0.
- Read: Sys_RdData carries the addressed register in the cycle after Sys_RdEn & Sys_BlockSelect; it is 0 in every other cycle.
- Write: takes effect on the clock edge where Sys_WrEn & Sys_BlockSelect.
- Simultaneous read and write to the same register returns the old value.
- Input edge to PENDING set: 1 cycle without sync, 3 cycles with sync (see Configuration).
- PENDING set to K_IntReq high: +1 cycle (IDLE to REQ).
- I_IntAck high: K_IntReq is low the next cycle.
- Minimum spacing between two requests: 3 cycles.
- Reset asserted mid-handshake drops K_IntReq asynchronously and loses all pending state.

## Configuration
- EIC_SYNC_EN defined: IntReq and UrgentReq each pass through a 2-flop synchroniser before polarity and edge logic, adding 2 cycles of latency. The bench must account for these extra cycles.
- EIC_SYNC_EN undefined: inputs are used directly and must already be synchronous to Sys_Clock.

## Structure
- Shared package eic_pkg holds:
  - register index constants EIC_REG_ENABLE … EIC_REG_STATUS;
  - STATUS bit positions;
  - the FSM state enum eic_state_t;
  - the URGENT_ID = 0 constant.
- Sub-module eic_prio_enc: parametrised priority encoder. Input: the NUM_CH-bit candidate vector plus urgent. Outputs: valid and ID.

## Test plan
- Reset, then read each register: all return 0, and K_IntReq = 0 after reset.
- NUM_CH=8, ENABLE=0xFF, MODE=0xFF; pulse IntReq[5] then IntReq[2] in the same cycle -> K_IntID=3 first. Ack -> HOLD. Release ack -> K_IntID=6. PENDING reads 0x00 at the end.
- Urgent pulse while channel 0 is in REQ -> channel 0 is not preempted. After its ack, K_IntID=0. STATUS bit30 clears on ack.
- Level mode, POLARITY bit1=1; hold IntReq[1]=0 -> K_IntID=2 repeats after every ack until IntReq[1]=1. W1C on PENDING bit1 has no effect.
- ENABLE=0 with an edge on channel 4 -> PENDING=0x10, K_IntReq stays 0. Write ENABLE=0x10 -> request with ID 5 two cycles later. W1C of bit4 in the same cycle as a new edge leaves the bit set.
- Assert Sys_Reset low while K_IntReq=1 -> K_IntReq falls immediately. After release, no request until a new edge arrives.
